// File: rtl/stack_ctrl.sv
// LIFO sequencer for a DEPTH-row latch-based cell array.
// Owns the stack pointer, drives latch-safe row select/write enable timing, and registers popped data.
module stack_ctrl #(
   parameter int N     = 8,
   parameter int DEPTH = 8,
   parameter int SP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [N-1:0]     din,
   output logic [N-1:0]     dout,
   output logic             dout_valid,
   output logic             ready,
   output logic             full,
   output logic             empty,
   output logic [SP_W-1:0]  count,
   output logic             overflow,
   output logic             underflow,
   output logic [DEPTH-1:0] mem_row_sel,
   output logic             mem_write_en,
   output logic [N-1:0]     mem_wdata,
   input  logic [N-1:0]     mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      WR_SETUP,
      WR_HOLD,
      RD_SEL,
      RD_CAP
   } state_t;

   localparam logic [SP_W-1:0] DEPTH_C = SP_W'(DEPTH);
   localparam logic [SP_W-1:0] ONE_C   = SP_W'(1);

   state_t          state_q, state_d;
   logic [SP_W-1:0] count_q, count_d;
   logic [N-1:0]    dout_q, dout_d;
   logic [N-1:0]    wdata_q, wdata_d;
   logic            dout_valid_q, dout_valid_d;
   logic            overflow_q, overflow_d;
   logic            underflow_q, underflow_d;
   logic            full_w, empty_w;
   logic [DEPTH-1:0] row_sel_w;

   function automatic logic [DEPTH-1:0] onehot(input logic [SP_W-1:0] idx);
      return DEPTH'(1) << idx;
   endfunction

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         dout_q       <= '0;
         wdata_q      <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         wdata_q      <= wdata_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      dout_d       = dout_q;
      wdata_d      = wdata_q;
      dout_valid_d = 1'b0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A pop wins a simultaneous request unless there is nothing to pop.
            if (pop && !empty_w) begin
               state_d = RD_SEL;
            end else if (push) begin
               if (!full_w) begin
                  wdata_d = din;
                  state_d = WR_SETUP;
               end else begin
                  overflow_d = 1'b1;
               end
            end else if (pop) begin
               underflow_d = 1'b1;
            end
         end
         WR_SETUP: state_d = WR_HOLD;
         WR_HOLD: begin
            count_d = count_q + ONE_C;
            state_d = IDLE;
         end
         RD_SEL: state_d = RD_CAP;
         RD_CAP: begin
            dout_d       = mem_rdata;
            count_d      = count_q - ONE_C;
            dout_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Row select decodes straight from registered state so reset clears it immediately.
   always_comb begin
      row_sel_w = '0;
      unique case (state_q)
         WR_SETUP, WR_HOLD: row_sel_w = onehot(count_q);
         RD_SEL, RD_CAP:    row_sel_w = onehot(count_q - ONE_C);
         default:           row_sel_w = '0;
      endcase
   end

   assign mem_row_sel  = row_sel_w;
   assign mem_write_en = (state_q == WR_SETUP);
   assign mem_wdata    = wdata_q;
   assign dout         = dout_q;
   assign dout_valid   = dout_valid_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign ready        = (state_q == IDLE);
   assign full         = full_w;
   assign empty        = empty_w;
   assign count        = count_q;

   a_row_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(mem_row_sel));
   a_we_only_setup:   assert property (@(posedge clk) disable iff (rst)
                                       mem_write_en |-> (state_q == WR_SETUP));
   a_count_bound:     assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Controller that sequences a DEPTH-row array of N-bit latch-based memory-cell rows as a LIFO stack. Rows have a one-hot row select, a shared write enable and shared tri-state read data.
The block owns the stack pointer and full/empty status. It generates the row select, write enable and write data with latch-safe setup/hold sequencing, and captures popped data into a register. It sits between the stack's user interface and the cell array.

Parameters:
N, 8, data width of each row and of din/dout.
DEPTH, 8, number of rows; must be at least 2.
SP_W, 4, width of the stack pointer/count; 2^SP_W must be greater than DEPTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
push  input  1  push request, sampled only when ready=1.
pop  input  1  pop request, sampled only when ready=1.
din  input  N  data to push, sampled with push.
dout  output  N  last popped data, registered.
dout_valid  output  1  one-cycle pulse when dout is updated by a pop.
ready  output  1  high in IDLE only; requests are accepted only when high.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  SP_W  number of stored entries (stack pointer).
overflow  output  1  one-cycle pulse: push was rejected because the stack was full.
underflow  output  1  one-cycle pulse: pop was rejected because the stack was empty.
mem_row_sel  output  DEPTH  one-hot row select to the cell array; all-zero when idle.
mem_write_en  output  1  write enable to the cell array.
mem_wdata  output  N  write data to the cell array.
mem_rdata  input  N  shared tri-state read bus from the cell array.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE, count=0, dout=0.
  - dout_valid, overflow, underflow, mem_write_en = 0; mem_row_sel=0; mem_wdata=0.
  - Array contents are not cleared; the stack is logically empty.
- States: IDLE, WR_SETUP, WR_HOLD, RD_SEL, RD_CAP. ready=1 only in IDLE.
- IDLE request decode at edge E0:
  - push and pop both high: pop has priority if !empty; otherwise the push is taken.
  - Accepted push with !full: latch din into mem_wdata and go to WR_SETUP.
  - Accepted pop with !empty: go to RD_SEL.
  - push only (or both high with empty) and full: stay IDLE; overflow=1 for the cycle after E0.
  - pop only and empty: stay IDLE; underflow=1 for the cycle after E0.
  - Requests while ready=0 are ignored, not queued, and raise no flag.
- Write sequence:
  - WR_SETUP: mem_row_sel=onehot(count), mem_write_en=1.
  - WR_HOLD: mem_write_en=0; mem_row_sel and mem_wdata held for latch hold time.
  - At the WR_HOLD exit edge: count+=1, then return to IDLE. A push costs 2 busy cycles.
- Read sequence:
  - RD_SEL and RD_CAP: mem_row_sel=onehot(count-1), mem_write_en=0.
  - At the RD_CAP exit edge: dout<=mem_rdata, count-=1, dout_valid=1 for the next cycle, return to IDLE.
- mem_row_sel is all-zero in IDLE, so the read bus is undriven and mem_rdata is don't-care there.
- mem_write_en is never high in any state other than WR_SETUP.
- mem_row_sel is at most one-hot at all times.
- full and empty are combinational decodes of count. count never exceeds DEPTH and never wraps below 0.
- mem_wdata retains its last value outside a write.

Test Plan:
- Reset then idle: rst pulse mid-WR_SETUP -> immediately count=0, empty=1, mem_write_en=0, mem_row_sel=0, ready=1.
- Push order: push 0x11, 0x22, 0x33 (DEPTH=8):
  - Each push gives mem_row_sel 0x01, 0x02, 0x04 with mem_write_en high for exactly 1 cycle, then 1 hold cycle.
  - ready is low for 2 cycles per push; count ends at 3.
- Pop order: pop three times after the pushes above -> dout=0x33, 0x22, 0x11, each with a 1-cycle dout_valid pulse 2 cycles after acceptance; empty=1 at the end.
- Boundaries:
  - Fill to 8 -> full=1; a 9th push gives an overflow pulse, count stays 8, no mem_write_en.
  - Pop on empty gives an underflow pulse and no mem_row_sel activity.
- Simultaneous request: push=pop=1 with count=2 -> pop executes (count=1, dout=top).
- Simultaneous request on empty: push=pop=1 with count=0 -> push executes (count=1), no underflow.
